// File: rtl/envelope_vca.sv
// ----------------------------------------------------------------------------
// envelope_vca
//
// Amplitude stage that sits after the ADSR envelope generator. On each
// accepted ce strobe it captures one offset-binary oscillator sample and an
// 8-bit unsigned envelope gain. It then multiplies them with a sequential
// shift-add multiplier that consumes two envelope bits per clock. The scaled
// sample is re-centred on mid-scale and delivered with a one-cycle valid pulse.
//
//    out = MID + ((sample - MID) * envelope) >>> 8      (floors toward -inf)
//
// Ports
//    clk        in   system clock, all logic on the rising edge
//    rst        in   synchronous active-high reset
//    ce         in   sample strobe / start request
//    sample     in   BITS-bit oscillator sample, offset-binary
//    envelope   in   8-bit unsigned gain (255 ~ unity, 0 = silent)
//    out        out  BITS-bit scaled sample, offset-binary, held between results
//    out_valid  out  one-cycle pulse when out is updated
//    busy       out  high while a multiply is in progress
//    overrun    out  one-cycle pulse after a ce was dropped
// ----------------------------------------------------------------------------
module envelope_vca #(
   parameter int BITS = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ce,
   input  logic [BITS-1:0] sample,
   input  logic [7:0]      envelope,
   output logic [BITS-1:0] out,
   output logic            out_valid,
   output logic            busy,
   output logic            overrun
);

   // The product of a BITS+1 signed operand and an 8-bit unsigned gain needs
   // BITS+9 signed bits.
   localparam int              ACC_W = BITS + 9;
   localparam logic [BITS-1:0] MID   = {1'b1, {(BITS-1){1'b0}}};

   typedef enum logic {
      IDLE,
      MUL
   } state_e;

   state_e                  state_q, state_d;
   logic [1:0]              k_q, k_d;
   logic signed [BITS:0]    s_q, s_d;
   logic [7:0]              env_q, env_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [BITS-1:0]         out_q, out_d;
   logic                    out_valid_q, out_valid_d;
   logic                    overrun_q, overrun_d;

   // Offset-binary to two's complement is an MSB flip. The flipped MSB is
   // also the sign, so it is repeated once to widen to BITS+1 bits.
   logic signed [BITS:0]    s_new;
   assign s_new = {~sample[BITS-1], ~sample[BITS-1], sample[BITS-2:0]};

   // Partial product for the current 2-bit envelope digit, weighted by 4^k.
   logic [1:0]              digit;
   logic signed [ACC_W-1:0] s_ext;
   logic signed [ACC_W-1:0] digit_prod;
   logic signed [ACC_W-1:0] partial;
   logic signed [ACC_W-1:0] sum;

   always_comb begin
      // NOTE: every signal driven here gets a value on every path; a missing
      // default would infer a latch.
      digit = 2'(env_q >> {k_q, 1'b0});
      s_ext = ACC_W'(s_q);
      case (digit)
         2'd0:    digit_prod = '0;
         2'd1:    digit_prod = s_ext;
         2'd2:    digit_prod = s_ext <<< 1;
         default: digit_prod = s_ext + (s_ext <<< 1);
      endcase
      partial = digit_prod <<< {k_q, 1'b0};
      sum     = acc_q + partial;
   end

   // Next-state and output logic.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      s_d         = s_q;
      env_d       = env_q;
      acc_d       = acc_q;
      out_d       = out_q;
      out_valid_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (ce) begin
               s_d     = s_new;
               env_d   = envelope;
               acc_d   = '0;
               k_d     = 2'd0;
               state_d = MUL;
            end
         end

         MUL: begin
            acc_d = sum;
            k_d   = k_q + 2'd1;
            if (k_q == 2'd3) begin
               // The result is taken from the sum that includes this step's
               // partial product, so it lands exactly four edges after capture.
               // After the arithmetic shift by 8, the value fits in BITS bits
               // signed. The low BITS bits plus MID re-centre it.
               out_d       = MID + sum[BITS+7:8];
               out_valid_d = 1'b1;
               if (ce) begin
                  // A ce on the completion edge starts the next multiply at
                  // once, so a 4-clock strobe period runs back-to-back.
                  s_d   = s_new;
                  env_d = envelope;
                  acc_d = '0;
                  k_d   = 2'd0;
               end else begin
                  state_d = IDLE;
               end
            end else if (ce) begin
               overrun_d = 1'b1;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      if (rst) begin
         state_q     <= IDLE;
         k_q         <= 2'd0;
         s_q         <= '0;
         env_q       <= '0;
         acc_q       <= '0;
         out_q       <= MID;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         s_q         <= s_d;
         env_q       <= env_d;
         acc_q       <= acc_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
      end
   end

   assign out       = out_q;
   assign out_valid = out_valid_q;
   assign busy      = (state_q == MUL);
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_envelope_vca.sv
// ----------------------------------------------------------------------------
// tb_envelope_vca
//
// Self-checking bench for envelope_vca (BITS = 8). A monitor pops expected
// results from a scoreboard queue on every out_valid. A table of operand
// vectors covers the main arithmetic. Hand-written sequences cover the
// back-to-back, overrun and reset-abort cases.
// ----------------------------------------------------------------------------
module tb_envelope_vca;

   localparam int BITS = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            ce;
   logic [BITS-1:0] sample;
   logic [7:0]      envelope;
   logic [BITS-1:0] out;
   logic            out_valid;
   logic            busy;
   logic            overrun;

   int checks  = 0;
   int errors  = 0;
   int vld_cnt = 0;
   int ovr_cnt = 0;

   logic [7:0] exp_q[$];
   logic [7:0] mon_exp;

   typedef struct {
      logic [7:0] smp;
      logic [7:0] env;
      logic [7:0] exp_out;
   } vec_t;

   vec_t vecs[10];

   envelope_vca #(.BITS(BITS)) dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .sample    (sample),
      .envelope  (envelope),
      .out       (out),
      .out_valid (out_valid),
      .busy      (busy),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Step to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: MID + floor((sample - MID) * env / 256).
   function automatic logic [7:0] model(input logic [7:0] s, input logic [7:0] e);
      int p;
      p = (int'(s) - 128) * int'(e);
      return 8'(128 + (p >>> 8));
   endfunction

   // Scoreboard monitor, sampling on the falling edge.
   always @(negedge clk) begin
      if (overrun === 1'b1) ovr_cnt++;
      if (out_valid === 1'b1) begin
         vld_cnt++;
         if (exp_q.size() == 0) begin
            check("valid_without_expect", exp_q.size(), 1);
         end else begin
            mon_exp = exp_q.pop_front();
            check("out", out, mon_exp);
         end
      end
   end

   // One isolated multiply, with the cycle-exact busy/valid timing checked.
   task automatic run_vec(input logic [7:0] s, input logic [7:0] e, input logic [7:0] exp_out);
      sample   = s;
      envelope = e;
      ce       = 1'b1;
      exp_q.push_back(exp_out);
      tick();                          // E0
      ce       = 1'b0;
      sample   = 8'($urandom);
      envelope = 8'($urandom);
      for (int i = 0; i < 4; i++) begin
         check("busy_during_mul", busy, 1);
         check("valid_early", out_valid, 0);
         tick();
      end
      check("valid_at_e4", out_valid, 1);   // E0+4
      check("busy_after_done", busy, 0);
   endtask

   int v0;
   int o0;
   logic [7:0] bb_s;
   logic [7:0] bb_e;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{8'd255, 8'd255, 8'd254};
      vecs[1] = '{8'd0,   8'd255, 8'd0};
      vecs[2] = '{8'd64,  8'd128, 8'd96};
      vecs[3] = '{8'd200, 8'd100, 8'd156};
      vecs[4] = '{8'd0,   8'd0,   8'd128};
      vecs[5] = '{8'd77,  8'd0,   8'd128};
      vecs[6] = '{8'd255, 8'd0,   8'd128};
      vecs[7] = '{8'd127, 8'd255, 8'd127};
      vecs[8] = '{8'd129, 8'd255, 8'd128};
      vecs[9] = '{8'd1,   8'd1,   8'd127};

      rst      = 1'b1;
      ce       = 1'b0;
      sample   = '0;
      envelope = '0;
      repeat (3) tick();
      check("rst_out", out, 128);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_overrun", overrun, 0);
      rst = 1'b0;
      tick();

      // Table-driven single multiplies.
      for (int i = 0; i < 10; i++) begin
         run_vec(vecs[i].smp, vecs[i].env, vecs[i].exp_out);
         tick();
      end

      // ce every 4 clocks with a ramping envelope: back-to-back, no overrun.
      v0 = vld_cnt;
      o0 = ovr_cnt;
      for (int i = 0; i < 16; i++) begin
         bb_s     = 8'($urandom);
         bb_e     = 8'(i * 16 + 15);
         sample   = bb_s;
         envelope = bb_e;
         ce       = 1'b1;
         exp_q.push_back(model(bb_s, bb_e));
         tick();
         ce       = 1'b0;
         sample   = 8'($urandom);
         envelope = 8'($urandom);
         repeat (3) begin
            check("b2b_busy", busy, 1);
            tick();
         end
      end
      tick();                          // completion of the last multiply
      tick();
      check("b2b_valid_count", vld_cnt - v0, 16);
      check("b2b_overrun_count", ovr_cnt - o0, 0);
      check("b2b_idle_after", busy, 0);

      // Extra ce at E0+2 is dropped; operands stay latched from E0.
      v0 = vld_cnt;
      o0 = ovr_cnt;
      sample   = 8'd200;
      envelope = 8'd100;
      ce       = 1'b1;
      exp_q.push_back(8'd156);
      tick();                          // E0
      ce       = 1'b0;
      sample   = 8'd10;
      tick();                          // E0+1
      ce       = 1'b1;
      sample   = 8'd250;
      envelope = 8'd250;
      tick();                          // E0+2
      ce       = 1'b0;
      check("overrun_pulse", overrun, 1);
      tick();                          // E0+3
      check("overrun_one_cycle", overrun, 0);
      tick();                          // E0+4
      check("ovr_valid_at_e4", out_valid, 1);
      repeat (4) tick();
      check("ovr_valid_count", vld_cnt - v0, 1);
      check("ovr_overrun_count", ovr_cnt - o0, 1);
      check("ovr_idle", busy, 0);

      // Reset at E0+2 aborts the multiply; ce on the reset edge is ignored.
      v0 = vld_cnt;
      sample   = 8'd255;
      envelope = 8'd255;
      ce       = 1'b1;
      tick();                          // E0
      ce       = 1'b0;
      tick();                          // E0+1
      rst      = 1'b1;
      ce       = 1'b1;
      tick();                          // E0+2
      rst      = 1'b0;
      ce       = 1'b0;
      check("abort_out", out, 128);
      check("abort_busy", busy, 0);
      check("abort_valid", out_valid, 0);
      repeat (5) tick();
      check("abort_no_valid", vld_cnt - v0, 0);
      check("abort_still_idle", busy, 0);
      run_vec(8'd64, 8'd128, 8'd96);

      repeat (3) tick();
      check("scoreboard_empty", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
